// File: rtl/ask_demod_param.sv
// Non-coherent ASK demodulator: |din| -> boxcar envelope -> leaky-mean slicer -> DPLL bit sync; 1 clk per stage.
// Advances only on din_valid strobes (no backpressure); ASK_LOCK_DET_EN adds the lock counter, else locked=0.
module ask_demod_param #(
    parameter int DW         = 8,
    parameter int LPF_LOG2   = 4,
    parameter int MEAN_SHIFT = 10,
    parameter int SPB        = 16,
    parameter int HYST       = 0,
    parameter int LOCK_N     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DW-1:0]       din,
    input  logic                       din_valid,
    output logic [DW+LPF_LOG2-1:0]     env,
    output logic [DW+LPF_LOG2-1:0]     mean,
    output logic                       demod,
    output logic                       data_out,
    output logic                       bit_valid,
    output logic                       bit_sync,
    output logic                       locked
);
    localparam int EW   = DW + LPF_LOG2;
    localparam int N    = 1 << LPF_LOG2;
    localparam int AW   = EW + MEAN_SHIFT;
    localparam int PW   = $clog2(SPB);
    localparam int HALF = SPB / 2;

    logic [DW-1:0] din_u;
    logic [DW-1:0] mag;
    logic [DW-1:0] dly [N];
    logic [EW-1:0] env_nxt;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [EW:0]   env_x, mean_x, hi, lo;
    logic          above, below, demod_nxt;
    logic          demod_d, trans;
    logic [PW-1:0] ph, ph_inc, ph_nxt;
    logic          corr_done, smp_done, do_corr, wrap, fire;

    // Two's-complement magnitude; the most negative input maps to 2^(DW-1) as unsigned.
    assign din_u = din;
    assign mag   = din_u[DW-1] ? (~din_u) + DW'(1) : din_u;

    // Modular arithmetic is exact here because the true sum never leaves 0..N*2^(DW-1).
    assign env_nxt = env + EW'(mag) - EW'(dly[N-1]);
    assign acc_nxt = acc + AW'(env) - (acc >> MEAN_SHIFT);
    assign mean    = acc[AW-1:MEAN_SHIFT];

    assign env_x     = {1'b0, env};
    assign mean_x    = {1'b0, mean};
    assign hi        = mean_x + (EW+1)'(HYST);
    assign lo        = mean_x - (EW+1)'(HYST);
    assign above     = env_x > hi;
    assign below     = (mean_x > (EW+1)'(HYST)) && (env_x < lo);
    assign demod_nxt = above | (demod & ~below);
    assign trans     = demod ^ demod_d;

    always_comb begin
        do_corr = trans && !corr_done && (ph != '0);
        ph_inc  = (ph == PW'(SPB-1)) ? '0 : ph + PW'(1);
        ph_nxt  = ph_inc;
        if (do_corr) begin
            if (ph < PW'(HALF))
                ph_nxt = ph;
            else if (ph >= PW'(SPB-2))
                ph_nxt = ph - PW'(SPB-2);
            else
                ph_nxt = ph + PW'(2);
        end
        // An advance across SPB-1 counts as a wrap so the next bit period may correct again.
        wrap = ph_nxt < ph;
        fire = (ph == PW'(HALF-1)) && !smp_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) dly[i] <= '0;
        end else if (din_valid) begin
            dly[0] <= mag;
            for (int i = 1; i < N; i++) dly[i] <= dly[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env       <= '0;
            acc       <= '0;
            demod     <= 1'b0;
            demod_d   <= 1'b0;
            ph        <= '0;
            corr_done <= 1'b0;
            smp_done  <= 1'b0;
            data_out  <= 1'b0;
            bit_valid <= 1'b0;
            bit_sync  <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (din_valid) begin
                env       <= env_nxt;
                acc       <= acc_nxt;
                demod     <= demod_nxt;
                demod_d   <= demod;
                ph        <= ph_nxt;
                corr_done <= wrap ? 1'b0 : (corr_done | do_corr);
                smp_done  <= wrap ? 1'b0 : (smp_done | fire);
                bit_valid <= fire;
                if (fire) data_out <= demod;
                bit_sync  <= ph_nxt < PW'(HALF);
            end
        end
    end

`ifdef ASK_LOCK_DET_EN
    localparam int LW = $clog2(LOCK_N + 1);
    logic [LW-1:0] lc, lc_nxt;
    logic [PW-1:0] dist;
    logic          in_win, far;

    always_comb begin
        dist   = (ph < PW'(HALF)) ? ph : PW'(SPB) - ph;
        in_win = (ph == '0) || (ph == PW'(1)) || (ph == PW'(SPB-1));
        far    = dist > PW'(SPB/4);
        lc_nxt = lc;
        if (trans && in_win && (lc != LW'(LOCK_N)))
            lc_nxt = lc + LW'(1);
        else if (trans && far && (lc != '0))
            lc_nxt = lc - LW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lc     <= '0;
            locked <= 1'b0;
        end else if (din_valid) begin
            lc     <= lc_nxt;
            locked <= lc_nxt == LW'(LOCK_N);
        end
    end
`else
    assign locked = 1'b0;
`endif
endmodule

// File: tb/tb_ask_demod_param.sv
// Scoreboarded bench for ask_demod_param: per-strobe expectations plus a recovered-bit queue.
module tb_ask_demod_param;
    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] din;
    logic              din_valid;
    logic [11:0]       env, mean;
    logic              demod, data_out, bit_valid, bit_sync, locked;

`ifdef ASK_LOCK_DET_EN
    localparam int EXP_LOCK = 1;
`else
    localparam int EXP_LOCK = 0;
`endif

    ask_demod_param dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .env(env), .mean(mean), .demod(demod), .data_out(data_out),
        .bit_valid(bit_valid), .bit_sync(bit_sync), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit c_env;   int env;
        bit c_mean;  int mean;
        bit c_demod; int demod;
        bit c_sync;  int bsync;
        bit c_bv;    int bv;
        bit c_dout;  int dout;
    } exp_t;

    exp_t eq[$];
    int   bq[$];
    int   total = 0, passed = 0;
    int   gap = 0, nbits = 0;
    bit   bchk = 0, saw_unlock = 0;
    bit   pat [7] = '{1, 1, 0, 0, 1, 0, 1};

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_env"}, env, 0);
        chk({tag, "_mean"}, mean, 0);
        chk({tag, "_demod"}, demod, 0);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_bv"}, bit_valid, 0);
        chk({tag, "_sync"}, bit_sync, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    task automatic send(input logic signed [7:0] x, input exp_t e, input bit push);
        din = x;
        din_valid = 1'b1;
        if (push) eq.push_back(e);
        @(negedge clk);
        if (gap > 0) begin
            din_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        din = 8'sd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("rst");
    endtask

    function automatic logic signed [7:0] tone(input bit b, input int j);
        if (!b) return 8'sd0;
        return (j % 2 != 0) ? -8'sd100 : 8'sd100;
    endfunction

    // Monitor: one expectation per strobe; recovered bits popped on bit_valid.
    exp_t me;
    bit   ms;
    initial forever begin
        @(posedge clk);
        ms = din_valid && !rst;
        @(negedge clk);
        if (bit_valid) chk("bv_on_strobe", ms, 1);
        if (ms && eq.size() > 0) begin
            me = eq.pop_front();
            if (me.c_env)   chk("env", env, me.env);
            if (me.c_mean)  chk("mean", mean, me.mean);
            if (me.c_demod) chk("demod", demod, me.demod);
            if (me.c_sync)  chk("bit_sync", bit_sync, me.bsync);
            if (me.c_bv)    chk("bit_valid", bit_valid, me.bv);
            if (me.c_dout)  chk("data_out", data_out, me.dout);
        end
        if (ms && bit_valid && bchk) begin
            chk("bit_queue_nonempty", int'(bq.size() > 0), 1);
            if (bq.size() > 0) begin
                chk("bit_data", data_out, bq.pop_front());
                nbits++;
            end
        end
        if (!locked) saw_unlock = 1'b1;
    end

    task automatic send_bit(input bit b, input bit push, input int idx);
        for (int j = 0; j < 16; j++) begin
            exp_t e;
            e = '{default: 0};
            if (push && j == 0) bq.push_back(int'(b));
            if (idx == 0 && j == 4) bchk = 1'b1;
            if (idx == -1 && j == 12) bchk = 1'b0;
            send(tone(b, j), e, 1'b0);
        end
    endtask

    task automatic run_bits(input int g, input bit noise);
        exp_t e;
        e = '{default: 0};
        gap = g;
        do_reset();
        nbits = 0;
        bq.delete();
        repeat (7) send(8'sd0, e, 1'b0);
        for (int b = 0; b < 250; b++) send_bit(b % 2 == 0, 1'b0, 1);
        chk("locked_after_preamble", locked, EXP_LOCK);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 7; i++) send_bit(pat[i], 1'b1, r * 7 + i);
        send_bit(1'b1, 1'b0, -1);
        send_bit(1'b0, 1'b0, 1);
        chk("bits_recovered", nbits, 21);
        chk("bits_left", bq.size(), 0);
        if (noise) begin
            saw_unlock = 1'b0;
            for (int k = 0; k < 2000; k++) begin
                int r;
                r = $urandom_range(2, 0);
                send((r == 0) ? 8'sd0 : (r == 1) ? 8'sd100 : -8'sd100, e, 1'b0);
            end
            chk("unlock_under_noise", saw_unlock, 1);
        end
        din_valid = 1'b0;
        gap = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int macc, menv;
        exp_t e;
        rst = 1'b1;
        din = 8'sd0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("por");

        // Idle: zeros for 100 strobes.
        for (int s = 0; s < 100; s++) begin
            e = '{default: 0};
            e.c_env = 1; e.c_mean = 1; e.c_demod = 1; e.c_dout = 1;
            e.c_sync = 1; e.bsync = ((s + 1) % 16 < 8) ? 1 : 0;
            e.c_bv = 1;   e.bv = (s % 16 == 7) ? 1 : 0;
            send(8'sd0, e, 1'b1);
        end
        din_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Envelope fill with +-100 alternating.
        do_reset();
        macc = 0;
        menv = 0;
        for (int k = 1; k <= 40; k++) begin
            e = '{default: 0};
            macc = macc + menv - (macc >> 10);
            menv = 100 * ((k < 16) ? k : 16);
            e.c_env = 1;   e.env = menv;
            e.c_mean = 1;  e.mean = macc >> 10;
            e.c_demod = 1; e.demod = (k >= 2) ? 1 : 0;
            send((k % 2 != 0) ? 8'sd100 : -8'sd100, e, 1'b1);
        end

        // Asynchronous reset in the middle of a strobe stream.
        e = '{default: 0};
        repeat (5) send(8'sd100, e, 1'b0);
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_rel");

        // Full-scale negative input saturates at 2048 without wrap.
        for (int k = 1; k <= 20; k++) begin
            e = '{default: 0};
            e.c_env = 1; e.env = 128 * ((k < 16) ? k : 16);
            send(8'sh80, e, 1'b1);
        end
        din_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Single full-scale impulse stays in the window for exactly 16 strobes.
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            e = '{default: 0};
            e.c_env = 1; e.env = (k <= 16) ? 128 : 0;
            send((k == 1) ? 8'sh80 : 8'sd0, e, 1'b1);
        end
        din_valid = 1'b0;
        repeat (2) @(negedge clk);

        run_bits(0, 1'b1);
        run_bits(2, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
